fuzz_stim_sequencer: RTL and testbench

Hardware stimulus sequencer for the fuzz harness, sitting between the run controller and the DUT under test. It drives the DUT's reset and its flat input bus from the deterministic 32-bit LCG stream that the software bench uses, for a programmed number of cycles. It compresses the DUT's flat output bus into a 32-bit signature so results can be compared across simulators and FPGA runs.

---
 rtl/fuzz_stim_sequencer.sv | 111 +++++++++++
 tb/tb_fuzz_stim_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fuzz_stim_sequencer.sv
// fuzz_stim_sequencer: drives DUT reset and LCG stimulus for a run and folds DUT responses into a signature
module fuzz_stim_sequencer #(
    parameter int IN_W          = 136,
    parameter int OUT_W         = 159,
    parameter int RST_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] cycles,
    output logic             busy,
    output logic             done,
    output logic             dut_rst_n,
    output logic [IN_W-1:0]  in_flat,
    input  logic [OUT_W-1:0] out_flat,
    output logic [CNT_W-1:0] cyc_count,
    output logic [31:0]      signature
);
    localparam int NW = (IN_W + 31) / 32;
    localparam int NO = (OUT_W + 31) / 32;
    typedef enum logic [2:0] {IDLE, RESET, SETTLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [31:0]      rng, ph_cnt, lcg_s, fold_w;
    logic [CNT_W-1:0] budget, cnt_nx;
    logic [32*NW-1:0] vec;
    logic [32*NO-1:0] out_ext;
    logic             ph_last, run_last;
    // Chain NW LCG steps from the seed (IDLE) or the running state; the last step becomes the next rng
    always_comb begin
        lcg_s = (state == IDLE) ? seed : rng;
        vec = '0;
        for (int k = 0; k < NW; k++) begin
            lcg_s = lcg_s * 32'h41C64E6D + 32'h3039;
            vec[32*k +: 32] = lcg_s;
        end
    end
    // XOR-fold the zero-extended response bus into one 32-bit word
    always_comb begin
        out_ext = '0;
        out_ext[OUT_W-1:0] = out_flat;
        fold_w = '0;
        for (int k = 0; k < NO; k++) fold_w = fold_w ^ out_ext[32*k +: 32];
    end
    assign cnt_nx   = cyc_count + CNT_W'(1);
    assign run_last = (cnt_nx == budget);
    assign ph_last  = (state == RESET  && ph_cnt == 32'(RST_CYCLES - 1)) ||
                      (state == SETTLE && ph_cnt == 32'(SETTLE_CYCLES - 1));
    // Next-state and state-decoded outputs
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        dut_rst_n = 1'b0;
        case (state)
            IDLE:   state_nx = start ? RESET : IDLE;
            RESET: begin
                busy     = 1'b1;
                state_nx = ph_last ? SETTLE : RESET;
            end
            SETTLE: begin
                busy      = 1'b1;
                dut_rst_n = 1'b1;
                state_nx  = ph_last ? ((budget == '0) ? DONE : RUN) : SETTLE;
            end
            RUN: begin
                busy      = 1'b1;
                dut_rst_n = 1'b1;
                state_nx  = run_last ? DONE : RUN;
            end
            DONE: begin
                done      = 1'b1;
                dut_rst_n = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // Phase timer, run budget, stimulus, counter and signature
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt    <= '0;
            budget    <= '0;
            rng       <= '0;
            in_flat   <= '0;
            cyc_count <= '0;
            signature <= '0;
        end else begin
            ph_cnt <= (state_nx != state) ? '0 : ph_cnt + 32'd1;
            if (state == IDLE && start) begin
                budget    <= cycles;
                in_flat   <= vec[IN_W-1:0];
                rng       <= lcg_s;
                cyc_count <= '0;
                signature <= '0;
            end else if (state == RUN) begin
                in_flat   <= vec[IN_W-1:0];
                rng       <= lcg_s;
                cyc_count <= cnt_nx;
                signature <= {signature[30:0], signature[31]} ^ fold_w;
            end
        end
    end
endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// tb_fuzz_stim_sequencer: directed checks of run timing, LCG vectors and signature folding
module tb_fuzz_stim_sequencer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  seed = '0;
    logic [31:0]  cycles = '0;
    logic         busy, done, dut_rst_n;
    logic [135:0] in_flat;
    logic [158:0] out_flat = '0;
    logic [31:0]  cyc_count, signature;
    int           n_vec = 0;
    int           n_err = 0;

    fuzz_stim_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .cycles(cycles),
        .busy(busy), .done(done), .dut_rst_n(dut_rst_n), .in_flat(in_flat),
        .out_flat(out_flat), .cyc_count(cyc_count), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void vec_model(input logic [31:0] s_in, output logic [135:0] v, output logic [31:0] s_out);
        logic [31:0]  s = s_in;
        logic [159:0] f = '0;
        for (int k = 0; k < 5; k++) begin
            s = s * 32'h41C64E6D + 32'h3039;
            f[32*k +: 32] = s;
        end
        v = f[135:0];
        s_out = s;
    endfunction

    function automatic logic [31:0] fold(input logic [158:0] o);
        logic [159:0] e = {1'b0, o};
        logic [31:0]  r = '0;
        for (int k = 0; k < 5; k++) r = r ^ e[32*k +: 32];
        return r;
    endfunction

    task automatic do_run(input logic [31:0] sd, input logic [31:0] n, input logic [158:0] pat, input logic poke);
        logic [135:0] ev;
        logic [31:0]  s, esig;
        logic [158:0] p;
        start = 1'b1; seed = sd; cycles = n;
        tick();
        start = 1'b0;
        vec_model(sd, ev, s);
        chk("start_busy", busy, 1);
        chk("start_dut_rst", dut_rst_n, 0);
        chk("first_vec", in_flat, ev);
        chk("start_cnt", cyc_count, 0);
        chk("start_sig", signature, 0);
        if (sd == 32'd0) chk("seed0_words", in_flat[63:0], 64'hD3DC167E_00003039);
        if (sd == 32'd1) chk("seed1_word0", in_flat[31:0], 32'h41C67EA6);
        tick();
        chk("reset2_dut_rst", dut_rst_n, 0);
        chk("reset2_busy", busy, 1);
        tick();
        chk("settle_dut_rst", dut_rst_n, 1);
        chk("settle_busy", busy, 1);
        chk("settle_vec", in_flat, ev);
        tick();
        esig = '0;
        p = pat;
        for (int i = 0; i < int'(n); i++) begin
            out_flat = p;
            start = poke; seed = ~sd; cycles = n + 7;
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_vec", in_flat, ev);
            tick();
            esig = {esig[30:0], esig[31]} ^ fold(p);
            vec_model(s, ev, s);
            p = {p[157:0], p[158]};
            chk("run_cnt", cyc_count, i + 1);
            chk("run_sig", signature, esig);
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_dut_rst", dut_rst_n, 1);
        tick();
        start = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_dut_rst", dut_rst_n, 0);
        chk("hold_cnt", cyc_count, n);
        chk("hold_sig", signature, esig);
        chk("hold_vec", in_flat, ev);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dut_rst", dut_rst_n, 0);
        chk("rst_vec", in_flat, 0);
        chk("rst_cnt", cyc_count, 0);
        chk("rst_sig", signature, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_run(32'd0, 32'd3, 159'h5A5A_1234_ABCD_0F0F_DEAD_BEEF_CAFE_F00D_1357_9BDF, 1'b0);
        do_run(32'd0, 32'd0, 159'h1, 1'b0);
        do_run(32'd5, 32'd1, 159'h1, 1'b0);
        chk("sig_one", signature, 32'h1);
        do_run(32'd7, 32'd5, 159'h0, 1'b0);
        chk("sig_zero", signature, 32'h0);
        do_run(32'h1234, 32'd4, {5{32'h8765_4321}}, 1'b0);
        do_run(32'h1234, 32'd4, {5{32'h8765_4321}}, 1'b0);
        do_run(32'd1, 32'd2, 159'h7F, 1'b0);
        do_run(32'hBEEF, 32'd6, 159'h3_0000_0001_0000_0002, 1'b1);
        start = 1'b1; seed = 32'd3; cycles = 32'd10;
        tick();
        start = 1'b0;
        out_flat = 159'hFFFF_0000_FFFF;
        repeat (5) tick();
        chk("mid_run_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_dut_rst", dut_rst_n, 0);
        chk("arst_vec", in_flat, 0);
        chk("arst_cnt", cyc_count, 0);
        chk("arst_sig", signature, 0);
        tick();
        chk("arst_hold_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("post_arst_idle", busy, 0);
        do_run(32'd0, 32'd3, 159'h5A5A_1234_ABCD_0F0F_DEAD_BEEF_CAFE_F00D_1357_9BDF, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
